addreg_sequencer: RTL
=====================

Name: addreg_sequencer

Overview:
- Command-driven controller for the team's 4x4-bit register file + 4-bit ripple adder datapath (registers q0..q3, operand mux, adder, per-register load).
- Accepts one 8-bit command at a time over a valid/ready handshake.
- Drives the operand selects and the one-hot register load strobes, captures the adder carry, and reports completion.
- Sits between the top-level command source (switch/board logic) and the datapath. Does not hold register data itself.

Parameters:
- DW, 4, datapath word width (sum_i width; carry taken from adder cout_i).
- NREG, 4, number of registers; fixed at 4 (2-bit register fields). Other values unsupported.

Ports:
- ck  in  1  clock, rising edge
- res  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd  in  8  {op[7:6], rd[5:4], ra[3:2], rb[1:0]}
- cmd_ready  out  1  controller can accept a command
- cout_i  in  1  adder carry-out from datapath
- x_sel  out  2  adder operand X register select (q0..q3)
- x_zero  out  1  force adder X operand to 0
- y_src  out  2  adder Y source: 0 = register y_sel, 1 = switch, 2 = zero, 3 = reserved (zero)
- y_sel  out  2  adder operand Y register select
- load  out  4  one-hot register write strobe (load[n] writes adder sum into qn)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- carry_flag  out  1  last captured carry

Behaviour:
- Opcodes (shared package):
  - CLR=0: rd <= 0 + 0; carry_flag <= 0.
  - LDS=1: rd <= 0 + switch; carry_flag unchanged.
  - ADD=2: rd <= q[ra] + q[rb]; carry_flag <= cout_i.
  - ADDS=3: rd <= q[ra] + switch; carry_flag <= cout_i.
- FSM states: IDLE, OPER, WB, DONE. All outputs are registered.
  - IDLE: cmd_ready=1, busy=0. Handshake fires when cmd_valid && cmd_ready at a rising edge: latch cmd, go to OPER.
  - OPER (1 cycle): x_sel=ra, y_sel=rb, and x_zero/y_src set per opcode. CLR: x_zero=1, y_src=2. LDS: x_zero=1, y_src=1. ADD: x_zero=0, y_src=0. ADDS: x_zero=0, y_src=1. Go to WB.
  - WB (1 cycle): selects held unchanged; load = one-hot(rd). At the edge ending WB, the datapath writes sum and carry_flag updates per opcode from cout_i. Go to DONE.
  - DONE (1 cycle): done=1, load=0, selects held. Go to IDLE.
- cmd_ready=1 only in IDLE; busy=1 in OPER, WB and DONE.
- Latency: done is high in the 3rd cycle after the accept edge. Throughput: one command per 4 cycles. A command presented in DONE is accepted on the following IDLE cycle.
- cmd_valid dropping before acceptance is allowed (no commitment until the handshake). cmd changes after acceptance are ignored (latched copy used).
- In each command, exactly one load bit pulses, for exactly one cycle. load is never high outside WB.
- Reset (res=0, any time, including mid-WB):
  - state=IDLE, load=0, done=0, busy=0, carry_flag=0.
  - x_sel=0, y_sel=0, x_zero=1, y_src=2.
  - cmd_ready goes to 1 in IDLE after reset release. A write interrupted by reset does not complete.
- Selects outside OPER/WB hold their last value (after reset: zero-operand defaults).

Decomposition:
- Package addreg_pkg: opcode constants (OP_CLR/OP_LDS/OP_ADD/OP_ADDS), Y source constants (YS_REG/YS_SW/YS_ZERO), state encoding, command field bit positions.
- One natural sub-module: addreg_decode (combinational opcode -> x_zero/y_src/carry_update). Everything else stays in addreg_sequencer.
- The bench instantiates the existing register-file/adder datapath as the DUT load.

Test Plan:
- Reset, then LDS rd=0 (cmd=8'h40), switch=5 -> accept in cycle 0; OPER cycle 1 with x_zero=1, y_src=1; WB cycle 2 with load=4'b0001; done in cycle 3; q0=5; carry_flag=0.
- q0=9, q1=8, ADD rd=2 ra=0 rb=1 (cmd=8'hA1) -> x_sel=0, y_sel=1, load=4'b0100 in WB; q2=1; carry_flag=1 after WB.
- Then CLR rd=3 (cmd=8'h30) -> load=4'b1000, q3=0, carry_flag=0.
- cmd_valid held high with two back-to-back commands -> second accepted only at the IDLE edge 4 cycles after the first; cmd_ready low for 3 cycles; no overlapping load pulses.
- ADDS rd=1 ra=2, q2=3, switch=4 (cmd=8'hD8) -> y_src=1, q1=7, carry_flag=0. Change cmd during OPER -> result unaffected.
- Assert res low during WB of an ADD -> load drops immediately (async); busy=0, carry_flag=0, done never pulses; next command executes normally after release.

Source files
------------

// File: rtl/addreg_pkg.sv
// Shared definitions for the register-file/adder command sequencer.
// Command word layout {op[7:6], rd[5:4], ra[3:2], rb[1:0]}, opcode and
// Y-operand source encodings, and the controller state encoding.
package addreg_pkg;

  localparam int CMD_W  = 8;
  localparam int REG_AW = 2;

  // Command field bit positions
  localparam int OP_LSB = 6;
  localparam int RD_LSB = 4;
  localparam int RA_LSB = 2;
  localparam int RB_LSB = 0;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LDS  = 2'd1,
    OP_ADD  = 2'd2,
    OP_ADDS = 2'd3
  } op_e;

  // Adder Y operand source; 3 is reserved and behaves as zero in the datapath
  localparam logic [1:0] YS_REG  = 2'd0;
  localparam logic [1:0] YS_SW   = 2'd1;
  localparam logic [1:0] YS_ZERO = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
  } cmd_t;

endpackage

// File: rtl/addreg_decode.sv
// Opcode decoder: operand forcing and carry-flag policy per opcode.
//   op        in   opcode
//   x_zero    out  force adder X operand to zero
//   y_src     out  adder Y operand source
//   carry_upd out  carry_flag takes adder cout at writeback
//   carry_clr out  carry_flag cleared at writeback
module addreg_decode
  import addreg_pkg::*;
(
  input  op_e        op,
  output logic       x_zero,
  output logic [1:0] y_src,
  output logic       carry_upd,
  output logic       carry_clr
);

  always_comb begin
    x_zero    = 1'b1;
    y_src     = YS_ZERO;
    carry_upd = 1'b0;
    carry_clr = 1'b0;
    case (op)
      OP_CLR:  carry_clr = 1'b1;
      OP_LDS:  y_src = YS_SW;
      OP_ADD:  begin x_zero = 1'b0; y_src = YS_REG; carry_upd = 1'b1; end
      OP_ADDS: begin x_zero = 1'b0; y_src = YS_SW;  carry_upd = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/addreg_sequencer.sv
// Command sequencer for the 4x4 register file + ripple adder datapath.
// One command per handshake, executed as OPER -> WB -> DONE, then IDLE.
//   ck, res            clock (rising), async active-low reset
//   cmd_valid/cmd      command in; cmd_ready high only in IDLE
//   cout_i             adder carry-out from the datapath
//   x_sel/x_zero       adder X operand register select / force zero
//   y_src/y_sel        adder Y operand source / register select
//   load               one-hot register write strobe, high only in WB
//   busy/done          command in progress / one-cycle completion pulse
//   carry_flag         last captured carry
// All outputs are flops whose next value is derived from the next state.
module addreg_sequencer
  import addreg_pkg::*;
#(
  parameter int DW   = 4,
  parameter int NREG = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             cmd_ready,
  input  logic             cout_i,
  output logic [1:0]       x_sel,
  output logic             x_zero,
  output logic [1:0]       y_src,
  output logic [1:0]       y_sel,
  output logic [NREG-1:0]  load,
  output logic             busy,
  output logic             done,
  output logic             carry_flag
);

  // Register fields are fixed at 2 bits, so only four registers are addressable.
  if (NREG != 4 || DW < 1) begin : g_param_check
    $error("addreg_sequencer: NREG must be 4 and DW positive");
  end

  state_e            state, state_n;
  cmd_t              cmd_in;
  op_e               op_q, op_n, dec_op;
  logic [REG_AW-1:0] rd_q, rd_n;
  logic              accept;

  logic [1:0]        x_sel_n, y_sel_n, y_src_n;
  logic              x_zero_n, carry_n, done_n, busy_n, ready_n;
  logic [NREG-1:0]   load_n;

  logic              d_xz, d_cupd, d_cclr;
  logic [1:0]        d_ys;

  assign cmd_in = cmd_t'(cmd);
  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

  // Decode the incoming opcode while idle (for the OPER selects), the
  // latched opcode otherwise (for the WB carry policy).
  assign dec_op = (state == S_IDLE) ? cmd_in.op : op_q;

  addreg_decode u_dec (
    .op        (dec_op),
    .x_zero    (d_xz),
    .y_src     (d_ys),
    .carry_upd (d_cupd),
    .carry_clr (d_cclr)
  );

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    rd_n     = rd_q;
    x_sel_n  = x_sel;
    y_sel_n  = y_sel;
    x_zero_n = x_zero;
    y_src_n  = y_src;
    carry_n  = carry_flag;
    load_n   = '0;
    done_n   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        state_n  = S_OPER;
        op_n     = cmd_in.op;
        rd_n     = cmd_in.rd;
        x_sel_n  = cmd_in.ra;
        y_sel_n  = cmd_in.rb;
        x_zero_n = d_xz;
        y_src_n  = d_ys;
      end
      S_OPER: begin
        state_n = S_WB;
        load_n  = {{(NREG-1){1'b0}}, 1'b1} << rd_q;
      end
      S_WB: begin
        // cout_i reflects the operands that are being written this edge.
        state_n = S_DONE;
        done_n  = 1'b1;
        if (d_cclr)      carry_n = 1'b0;
        else if (d_cupd) carry_n = cout_i;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    busy_n  = (state_n != S_IDLE);
    ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      op_q       <= OP_CLR;
      rd_q       <= '0;
      x_sel      <= '0;
      y_sel      <= '0;
      x_zero     <= 1'b1;
      y_src      <= YS_ZERO;
      load       <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b1;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      rd_q       <= rd_n;
      x_sel      <= x_sel_n;
      y_sel      <= y_sel_n;
      x_zero     <= x_zero_n;
      y_src      <= y_src_n;
      load       <= load_n;
      done       <= done_n;
      busy       <= busy_n;
      cmd_ready  <= ready_n;
      carry_flag <= carry_n;
    end
  end

endmodule
